spike_mac_pe: RTL

// - Clocked, parametrised binary-ifmap MAC processing element (PE) for the PE array.
// - Holds a NUM_TAPS x WEIGHT_WIDTH filter. Each accepted ifmap beat has one bit per tap;
//   the PE sums the weights whose bit is set and accumulates that sum over a window of beats.
// - At window end it emits one partial sum on a valid/ready output channel.
// - Supersedes the single-shot unclocked 9-tap MAC: adds configurable taps and widths,

---
 rtl/spike_mac_pe.sv | 137 +++++++++++++
 1 files changed

// File: rtl/spike_mac_pe.sv
// Binary-ifmap MAC processing element: sums the selected filter taps per beat and emits one partial sum per window.
// Optional build macro PSUM_SAT_EN makes the accumulator saturate instead of wrap.
module spike_mac_pe #(
  parameter int NUM_TAPS     = 9,
  parameter int WEIGHT_WIDTH = 8,
  parameter int PSUM_WIDTH   = 16,
  parameter int MAX_STEPS    = 16,
  localparam int CNT_W       = $clog2(MAX_STEPS + 1)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             filt_valid,
  output logic                             filt_ready,
  input  logic [NUM_TAPS*WEIGHT_WIDTH-1:0] filt_data,
  input  logic                             if_valid,
  output logic                             if_ready,
  input  logic [NUM_TAPS-1:0]              if_data,
  input  logic                             if_last,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [PSUM_WIDTH-1:0]            out_data,
  output logic [CNT_W-1:0]                 out_steps,
  output logic                             dbg_state
);

  // Wide enough for one full beat sum, plus one carry bit above the accumulator.
  localparam int BSUM_W = WEIGHT_WIDTH + $clog2(NUM_TAPS + 1);
  localparam int ACC_W  = ((PSUM_WIDTH > BSUM_W) ? PSUM_WIDTH : BSUM_W) + 1;

  typedef enum logic {ST_LOAD = 1'b0, ST_RUN = 1'b1} state_e;

  state_e                                  state_q, state_d;
  logic [NUM_TAPS-1:0][WEIGHT_WIDTH-1:0]   weights_q, weights_d;
  logic [PSUM_WIDTH-1:0]                   acc_q, acc_d;
  logic [CNT_W-1:0]                        cnt_q, cnt_d;
  logic                                    out_valid_q, out_valid_d;
  logic [PSUM_WIDTH-1:0]                   out_data_q, out_data_d;
  logic [CNT_W-1:0]                        out_steps_q, out_steps_d;

  logic                  idle;
  logic                  filt_fire;
  logic                  if_fire;
  logic                  win_close;
  logic [BSUM_W-1:0]     beat_sum;
  logic [ACC_W-1:0]      acc_wide;
  logic [PSUM_WIDTH-1:0] acc_add;

  // All three channels use valid/ready: a transfer happens on a rising edge where both
  // are high; valid never depends on ready, ready may depend on valid (filter-first arbitration).
  assign idle      = (cnt_q == '0) && !out_valid_q;
  assign filt_fire = filt_valid && filt_ready;
  assign if_fire   = if_valid && if_ready;
  assign win_close = if_fire && (if_last || (cnt_q == CNT_W'(MAX_STEPS - 1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_LOAD;
      weights_q   <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_steps_q <= '0;
    end else begin
      state_q     <= state_d;
      weights_q   <= weights_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_steps_q <= out_steps_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOAD: if (filt_fire) state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_LOAD;
    endcase
  end

  always_comb begin
    filt_ready = 1'b1;
    if_ready   = 1'b0;
    if (state_q == ST_RUN) begin
      filt_ready = idle;
      if_ready   = !out_valid_q && !(idle && filt_valid);
    end
  end

  always_comb begin
    beat_sum = '0;
    for (int k = 0; k < NUM_TAPS; k++) begin
      if (if_data[k]) beat_sum = beat_sum + BSUM_W'(weights_q[k]);
    end
    acc_wide = ACC_W'(acc_q) + ACC_W'(beat_sum);
`ifdef PSUM_SAT_EN
    acc_add = (|acc_wide[ACC_W-1:PSUM_WIDTH]) ? '1 : acc_wide[PSUM_WIDTH-1:0];
`else
    acc_add = acc_wide[PSUM_WIDTH-1:0];
`endif
  end

  always_comb begin
    weights_d   = weights_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_steps_d = out_steps_q;
    if (filt_fire) weights_d = filt_data;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      out_data_d  = '0;
      out_steps_d = '0;
    end
    // if_ready is low while a result is pending, so a close never meets an output handshake.
    if (win_close) begin
      out_valid_d = 1'b1;
      out_data_d  = acc_add;
      out_steps_d = cnt_q + CNT_W'(1);
      acc_d       = '0;
      cnt_d       = '0;
    end else if (if_fire) begin
      acc_d = acc_add;
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_steps = out_steps_q;
  assign dbg_state = state_q;

endmodule
